seq_operator_unit: RTL

// Parametrised, clocked successor of the 2-bit combinational operator: WIDTH-bit

---
 rtl/seq_operator_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seq_operator_unit.sv
// Clocked WIDTH-bit operator unit: ADD/SUB/AND in one calc cycle, MUL by shift-add over
// WIDTH cycles, with valid/ready handshakes on operands and result.
module seq_operator_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ope,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             flag,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_MUL = 2'b11
    } op_t;

    state_t             state;
    op_t                op_code;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    logic [WIDTH:0]     add_full;
    logic [WIDTH-1:0]   alu_s;
    logic               alu_flag;

    assign add_full = {1'b0, op_a} + {1'b0, op_b};

    // Result selection; MUL reads the finished accumulator.
    always_comb begin
        alu_s    = '0;
        alu_flag = 1'b0;
        case (op_code)
            OP_ADD: begin
                alu_s    = add_full[WIDTH-1:0];
                alu_flag = add_full[WIDTH];
            end
            OP_SUB: begin
                alu_s    = op_a - op_b;
                alu_flag = (op_a < op_b);
            end
            OP_AND: begin
                alu_s    = op_a & op_b;
                alu_flag = ~|(op_a & op_b);
            end
            OP_MUL: begin
                alu_s    = acc[WIDTH-1:0];
                alu_flag = |acc[2*WIDTH-1:WIDTH];
            end
            default: begin
                alu_s    = '0;
                alu_flag = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_code   <= OP_ADD;
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            s         <= '0;
            flag      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= a;
                        op_b     <= b;
                        op_code  <= op_t'(ope);
                        cnt      <= CW'(WIDTH);
                        acc      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, a};
                        mplier   <= b;
                        state    <= CALC;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                CALC: begin
                    // Non-MUL ops finish on the first CALC edge; MUL after WIDTH steps.
                    if (op_code != OP_MUL || cnt == '0) begin
                        s         <= alu_s;
                        flag      <= alu_flag;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
